i2s_audio_transmitter: RTL
==========================

Name: i2s_audio_transmitter

Overview:
Consumer end of the 32-bit signed audio sample stream produced by the sample-fetch source model. Accepts samples over a valid/ready handshake and serializes them as standard Philips I2S: MSB first, one-bclk delay after each lrclk edge, stereo slots alternating left then right. Generates its own bit clock from the system clock. Sits between the audio source and the DAC pins in the audio test bench and in synthesizable designs.

Parameters:
WIDTH, 32, sample width and slot width in bits; frame length is 2*WIDTH bclk periods.
BCLK_DIV, 4, system clocks per bclk half-period, so bclk period is 2*BCLK_DIV clocks; must be >= 1.

Ports:
clock  input  1  system clock; every register updates on its rising edge.
reset  input  1  synchronous, active-high reset.
audio  input  WIDTH  signed sample; two's complement sent as-is.
audio_valid  input  1  audio is valid this cycle.
audio_ready  output  1  holding register empty; a transfer occurs when valid and ready are both high at a clock edge.
bclk  output  1  I2S bit clock.
lrclk  output  1  I2S word select: 0 = left, 1 = right.
sdata  output  1  I2S serial data, changes only in the cycle bclk falls.
underrun  output  1  one-clock pulse when a slot starts with no sample held.

Behaviour:
- Reset, applied at any time including mid-frame: the next edge sets the state to IDLE, bclk=0, lrclk=0, sdata=0, underrun=0, div_cnt=0 and bit index b=2*WIDTH-1. The held sample and the shift register are discarded. audio_ready=1 the cycle after reset.
- Holding register: one entry. audio_ready = !hold_valid (registered-state decode).
  - A transfer sets hold_valid.
  - A slot load clears it.
  - No accept occurs in the same cycle as a load, because ready was 0.
- IDLE:
  - Outputs are held at their reset values.
  - The first accepted sample moves the state to RUN on the same edge.
  - div_cnt starts counting from the next cycle.
- RUN:
  - div_cnt increments every clock.
  - At div_cnt==BCLK_DIV-1, div_cnt wraps to 0 and bclk toggles.
- Falling bclk (the edge where bclk goes 1->0), all registered on the same edge:
  - b advances to (b+1) mod 2*WIDTH.
  - lrclk = ((b_new+1) mod 2*WIDTH) >= WIDTH. lrclk is therefore low for b in {2W-1, 0..W-2} and high for b in {W-1..2W-2}, i.e. it changes one bclk before each slot MSB.
  - If b_new==0 (left slot) or b_new==WIDTH (right slot), the shift register loads hold if hold_valid, clearing hold_valid. Otherwise it loads zero and underrun pulses high for that one clock. sdata = MSB of the loaded value.
  - Otherwise the shift register shifts left by 1 and sdata = its new MSB.
- Rising bclk: no data or lrclk change.
- Channel order: accepted samples fill slots strictly in order L, R, L, R. An underrun slot still consumes its channel position; the next sample goes to the following slot.
- Latency: sample accepted at edge t (first sample from IDLE) gives the first bclk rise at edge t+BCLK_DIV and its MSB on sdata at edge t+2*BCLK_DIV with lrclk=0.
- RUN never returns to IDLE except via reset. Underruns emit zero slots continuously.
- Throughput: one sample per WIDTH bclk periods. The source can refill hold any time after a load, so a source asserting valid continuously never underruns.

Test Plan:
1. WIDTH=32, BCLK_DIV=2: reset, then audio=32'h8000_0001 valid at edge t -> bclk first rises at t+2; sdata=1 at t+4 with lrclk=0; 30 zeros follow, then 1; audio_ready returns to 1 at t+4.
2. Continuous valid stream L=32'h1234_5678, R=32'hA5A5_0F0F repeated -> sampling sdata on bclk rising edges recovers the exact words; lrclk flips at b=31 and b=63; frame=256 clocks; underrun never asserts.
3. Single sample, then valid held low -> right slot outputs 32 zeros; underrun pulses exactly one clock at b=32 and again at b=0 and b=32 of each later frame.
4. Valid held high while audio_ready=0 -> no transfer; the audio value presented after ready rises is the one transmitted; no sample is duplicated or dropped.
5. Assert reset mid-right-slot (b=45) for one cycle -> next edge bclk=0, lrclk=0, sdata=0, audio_ready=1; the held sample is lost; the next sample restarts from IDLE in the left slot.
6. BCLK_DIV=1 -> bclk toggles every clock; bclk period is 2 clocks; test 2 data still recovered bit-exact.

Source files
------------

// File: rtl/i2s_audio_transmitter_if.sv
// Sample handshake between an audio source and the I2S transmitter.
//   audio       : signed sample, two's complement
//   audio_valid : source has a sample this cycle
//   audio_ready : transmitter holding register is empty
// A transfer happens on a clock edge where audio_valid and audio_ready are both high.
interface i2s_audio_transmitter_if #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0] audio;
   logic             audio_valid;
   logic             audio_ready;

   modport master (output audio, output audio_valid, input audio_ready);
   modport slave  (input audio, input audio_valid, output audio_ready);
endinterface

// File: rtl/i2s_audio_transmitter.sv
// Philips I2S transmitter: serializes accepted samples into alternating left and right slots.
// Data is sent MSB first, one bclk after each lrclk edge. The bit clock is divided down from clock.
//   clock, reset : system clock and synchronous active-high reset
//   src          : sample handshake (slave side)
//   bclk         : I2S bit clock
//   lrclk        : word select, 0 = left, 1 = right
//   sdata        : serial data, changes only on the cycle bclk falls
//   underrun     : one-clock pulse when a slot starts with no sample held
module i2s_audio_transmitter #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned BCLK_DIV = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   i2s_audio_transmitter_if.slave src,
   output logic                   bclk,
   output logic                   lrclk,
   output logic                   sdata,
   output logic                   underrun
);

   localparam int unsigned FRAME = 2 * WIDTH;
   localparam int unsigned B_W   = (FRAME > 1) ? $clog2(FRAME) : 1;
   localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [B_W-1:0]     b_q, b_d;
   logic               bclk_q, bclk_d;
   logic               lrclk_q, lrclk_d;
   logic               sdata_q, sdata_d;
   logic               underrun_q, underrun_d;
   logic [WIDTH-1:0]   hold_q, hold_d;
   logic               hold_valid_q, hold_valid_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic               ready_q, ready_d;

   logic               accept;
   logic [B_W-1:0]     b_new;
   logic [B_W-1:0]     b_ahead;

   // Next-state and output decode
   always_comb begin
      state_d      = state_q;
      div_cnt_d    = div_cnt_q;
      b_d          = b_q;
      bclk_d       = bclk_q;
      lrclk_d      = lrclk_q;
      sdata_d      = sdata_q;
      underrun_d   = 1'b0;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      shreg_d      = shreg_q;
      b_new        = b_q;
      b_ahead      = b_q;

      accept = src.audio_valid && ready_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (div_cnt_q == DIV_W'(BCLK_DIV - 1)) begin
               div_cnt_d = '0;
               bclk_d    = ~bclk_q;
               // Falling bclk: advance bit index and drive the next data bit
               if (bclk_q) begin
                  b_new   = (b_q == B_W'(FRAME - 1)) ? '0 : b_q + B_W'(1);
                  b_ahead = (b_new == B_W'(FRAME - 1)) ? '0 : b_new + B_W'(1);
                  b_d     = b_new;
                  // Word select leads the slot MSB by one bclk
                  lrclk_d = (b_ahead >= B_W'(WIDTH));
                  if ((b_new == '0) || (b_new == B_W'(WIDTH))) begin
                     if (hold_valid_q) begin
                        shreg_d      = hold_q;
                        hold_valid_d = 1'b0;
                     end else begin
                        shreg_d    = '0;
                        underrun_d = 1'b1;
                     end
                  end else begin
                     shreg_d = shreg_q << 1;
                  end
                  sdata_d = shreg_d[WIDTH-1];
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Accept never coincides with a load: a load needs a full register, accept an empty one
      if (accept) begin
         hold_d       = src.audio;
         hold_valid_d = 1'b1;
      end

      ready_d = ~hold_valid_d;
   end

   // State registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         div_cnt_q    <= '0;
         b_q          <= B_W'(FRAME - 1);
         bclk_q       <= 1'b0;
         lrclk_q      <= 1'b0;
         sdata_q      <= 1'b0;
         underrun_q   <= 1'b0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         shreg_q      <= '0;
         ready_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         div_cnt_q    <= div_cnt_d;
         b_q          <= b_d;
         bclk_q       <= bclk_d;
         lrclk_q      <= lrclk_d;
         sdata_q      <= sdata_d;
         underrun_q   <= underrun_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         shreg_q      <= shreg_d;
         ready_q      <= ready_d;
      end
   end

   assign bclk            = bclk_q;
   assign lrclk           = lrclk_q;
   assign sdata           = sdata_q;
   assign underrun        = underrun_q;
   assign src.audio_ready = ready_q;

endmodule
